// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between NUM_REQ byte-stream requesters, the arbiter and one UART transmitter.
// The master side is whatever drives requests and models the UART; the arbiter uses the slave side.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 uart_ready;
  logic                 uart_send;
  logic [7:0]           uart_data;
  logic [IW-1:0]        grant;
  logic                 busy;
  logic                 abort;

  modport master (
    output req_valid, req_data, req_last, uart_ready,
    input  req_ready, uart_send, uart_data, grant, busy, abort
  );

  modport slave (
    input  req_valid, req_data, req_last, uart_ready,
    output req_ready, uart_send, uart_data, grant, busy, abort
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ packet streams, with optional
// channel header byte per packet and a stall timeout that releases the line.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter bit          HDR_EN  = 1'b1,
  parameter logic [3:0]  HDR_TAG = 4'hA,
  parameter int unsigned TIMEOUT = 1000000
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CntMax  = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LastIdx = IW'(NUM_REQ - 1);

  typedef enum logic [2:0] {StIdle, StHdr, StData, StGap, StWait} state_e;

  state_e               state_q;
  logic [IW-1:0]        grant_q;
  logic [IW-1:0]        rr_ptr_q;
  logic                 send_q;
  logic [7:0]           data_q;
  logic                 abort_q;
  logic                 is_last_q;
  logic [CW-1:0]        cnt_q;

  logic                 pick_found;
  logic [IW-1:0]        pick_idx;
  logic                 sel_valid;
  logic                 sel_last;
  logic [7:0]           sel_data;
  logic                 handshake;
  logic [NUM_REQ-1:0]   ready;
  logic [IW-1:0]        next_ptr;

  // First valid requester scanning upward from rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && bus.req_valid[IW'((32'(rr_ptr_q) + i) % NUM_REQ)]) begin
        pick_found = 1'b1;
        pick_idx   = IW'((32'(rr_ptr_q) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    sel_valid = bus.req_valid[grant_q];
    sel_last  = bus.req_last[grant_q];
    sel_data  = bus.req_data[{grant_q, 3'b000} +: 8];
    handshake = (state_q == StData) && bus.uart_ready && sel_valid;
    next_ptr  = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;
    ready     = '0;
    if (state_q == StData) begin
      ready[grant_q] = bus.uart_ready;
    end
  end

  assign bus.req_ready = ready;
  assign bus.uart_send = send_q;
  assign bus.uart_data = data_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.abort     = abort_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      send_q    <= 1'b0;
      data_q    <= '0;
      abort_q   <= 1'b0;
      is_last_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      send_q  <= 1'b0;
      abort_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (pick_found) begin
            grant_q <= pick_idx;
            state_q <= HDR_EN ? StHdr : StData;
          end
        end
        StHdr: begin
          if (bus.uart_ready) begin
            send_q    <= 1'b1;
            data_q    <= {HDR_TAG, 4'(grant_q)};
            is_last_q <= 1'b0;
            state_q   <= StGap;
          end
        end
        StData: begin
          if (handshake) begin
            send_q    <= 1'b1;
            data_q    <= sel_data;
            is_last_q <= sel_last;
            cnt_q     <= '0;
            state_q   <= StGap;
          end else if (!sel_valid && bus.uart_ready) begin
            // Stall time only accrues while the UART could actually take a byte.
            if (cnt_q == CntMax) begin
              abort_q  <= 1'b1;
              rr_ptr_q <= next_ptr;
              cnt_q    <= '0;
              state_q  <= StIdle;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        // UART drops ready one cycle after a send, so ready is not trusted here.
        StGap: state_q <= StWait;
        StWait: begin
          if (bus.uart_ready) begin
            if (is_last_q) begin
              rr_ptr_q <= next_ptr;
              state_q  <= StIdle;
            end else begin
              state_q <= StData;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: two arbiters (header on / header off) driven by per-requester byte queues and a
// simple UART model that logs every sent byte and holds ready low for a few cycles after each send.
module tb_uart_tx_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned UB = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus_a ();
  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus_b ();

  uart_tx_arbiter #(.NUM_REQ(NR), .HDR_EN(1'b1), .HDR_TAG(4'hA), .TIMEOUT(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  uart_tx_arbiter #(.NUM_REQ(NR), .HDR_EN(1'b0), .HDR_TAG(4'hA), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  logic [3:0]  rv   [2];
  logic [31:0] rdat [2];
  logic [3:0]  rl   [2];
  logic        ur   [2];
  logic [3:0]  rrdy [2];
  logic        snd  [2];
  logic [7:0]  udat [2];
  logic        ab   [2];
  logic        bsy  [2];

  assign bus_a.req_valid = rv[0];
  assign bus_a.req_data  = rdat[0];
  assign bus_a.req_last  = rl[0];
  assign bus_a.uart_ready = ur[0];
  assign bus_b.req_valid = rv[1];
  assign bus_b.req_data  = rdat[1];
  assign bus_b.req_last  = rl[1];
  assign bus_b.uart_ready = ur[1];
  assign rrdy[0] = bus_a.req_ready;
  assign rrdy[1] = bus_b.req_ready;
  assign snd[0]  = bus_a.uart_send;
  assign snd[1]  = bus_b.uart_send;
  assign udat[0] = bus_a.uart_data;
  assign udat[1] = bus_b.uart_data;
  assign ab[0]   = bus_a.abort;
  assign ab[1]   = bus_b.abort;
  assign bsy[0]  = bus_a.busy;
  assign bsy[1]  = bus_b.busy;

  logic [8:0] pq [2][4][16];
  int pw [2][4];
  int pr [2][4];
  logic hs [2][4];

  logic [7:0] lg [2][128];
  int nl [2];
  int ubz [2];
  int viol [2];
  int nab [2];
  int ab_cyc [2];
  int rise_cyc [2];
  int cyc;

  int n_chk;
  int n_bad;
  logic t6_on;
  int t6_base;
  int t6_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int d, input int i, input logic [7:0] b, input logic lst);
    pq[d][i][pw[d][i]] = {lst, b};
    pw[d][i]++;
  endtask

  task automatic flush(input int d);
    for (int i = 0; i < 4; i++) pr[d][i] = pw[d][i];
  endtask

  task automatic wait_log(input int d, input int n, input string tag);
    int k;
    k = 0;
    while (nl[d] < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(nl[d] >= n), 32'd1);
  endtask

  task automatic wait_idle(input int d, input string tag);
    int k;
    k = 0;
    while (bsy[d] && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(bsy[d]), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Requester driver: handshake decided mid-cycle, next byte presented just after the edge.
  initial begin
    for (int d = 0; d < 2; d++) begin
      rv[d] = '0; rdat[d] = '0; rl[d] = '0; ur[d] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        pw[d][i] = 0; pr[d][i] = 0; hs[d][i] = 1'b0;
      end
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 4; i++) hs[d][i] = rv[d][i] & rrdy[d][i];
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 4; i++) begin
          if (hs[d][i] && pr[d][i] < pw[d][i]) pr[d][i]++;
          if (pr[d][i] < pw[d][i]) begin
            rv[d][i] = 1'b1;
            rdat[d][8*i +: 8] = pq[d][i][pr[d][i]][7:0];
            rl[d][i] = pq[d][i][pr[d][i]][8];
          end else begin
            rv[d][i] = 1'b0;
            rdat[d][8*i +: 8] = 8'h00;
            rl[d][i] = 1'b0;
          end
        end
      end
    end
  end

  // UART model and event log.
  initial begin
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      nl[d] = 0; ubz[d] = 0; viol[d] = 0; nab[d] = 0; ab_cyc[d] = 0; rise_cyc[d] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (snd[d]) begin
          if (!ur[d]) viol[d]++;
          if (nl[d] < 128) lg[d][nl[d]] = udat[d];
          nl[d]++;
          ur[d] = 1'b0;
          ubz[d] = UB;
        end else if (ubz[d] > 0) begin
          ubz[d]--;
          if (ubz[d] == 0) begin
            ur[d] = 1'b1;
            rise_cyc[d] = cyc;
          end
        end
        if (ab[d]) begin
          nab[d]++;
          ab_cyc[d] = cyc;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (t6_on && rrdy[1][1] && nl[1] < t6_base + 3) t6_bad++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1);
  end

  initial begin
    int base;
    int nab0;
    int k;
    n_chk = 0; n_bad = 0; t6_on = 1'b0; t6_base = 0; t6_bad = 0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_send", 32'(bus_a.uart_send), 0);
    chk("rst_data", 32'(bus_a.uart_data), 0);
    chk("rst_grant", 32'(bus_a.grant), 0);
    chk("rst_busy", 32'(bus_a.busy), 0);
    chk("rst_abort", 32'(bus_a.abort), 0);
    chk("rst_rdy_b", 32'(bus_b.req_ready), 0);
    rst = 1'b1;

    // Reset while requester 1 is in DATA.
    base = nl[0];
    push(0, 1, 8'h77, 1'b0);
    push(0, 1, 8'h78, 1'b1);
    wait_log(0, base + 1, "t1_hdr_sent");
    chk("t1_hdr", 32'(lg[0][base]), 32'hA1);
    k = 0;
    while (!rrdy[0][1] && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t1_in_data", 32'(rrdy[0][1]), 1);
    rst = 1'b0;
    #1;
    chk("t1_rst_send", 32'(bus_a.uart_send), 0);
    chk("t1_rst_data", 32'(bus_a.uart_data), 0);
    chk("t1_rst_rdy", 32'(bus_a.req_ready), 0);
    chk("t1_rst_grant", 32'(bus_a.grant), 0);
    chk("t1_rst_busy", 32'(bus_a.busy), 0);
    chk("t1_rst_abort", 32'(bus_a.abort), 0);
    flush(0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    base = nl[0];
    push(0, 0, 8'h01, 1'b1);
    wait_log(0, base + 2, "t1_pkt_sent");
    chk("t1_grant0", 32'(bus_a.grant), 0);
    chk("t1_hdr0", 32'(lg[0][base]), 32'hA0);
    chk("t1_byte", 32'(lg[0][base+1]), 32'h01);
    wait_idle(0, "t1_idle");

    // Single requester 2, two-byte packet with header.
    base = nl[0];
    push(0, 2, 8'h55, 1'b0);
    push(0, 2, 8'h66, 1'b1);
    wait_log(0, base + 3, "t2_sent");
    chk("t2_busy_hi", 32'(bsy[0]), 1);
    chk("t2_b0", 32'(lg[0][base]), 32'hA2);
    chk("t2_b1", 32'(lg[0][base+1]), 32'h55);
    chk("t2_b2", 32'(lg[0][base+2]), 32'h66);
    wait_idle(0, "t2_idle");
    chk("t2_count", 32'(nl[0]), 32'(base + 3));

    // Requesters 0 and 3 alternate.
    do_reset();
    base = nl[0];
    push(0, 0, 8'h01, 1'b1);
    push(0, 0, 8'h02, 1'b1);
    push(0, 3, 8'h31, 1'b1);
    push(0, 3, 8'h32, 1'b1);
    wait_log(0, base + 8, "t3_sent");
    chk("t3_h0", 32'(lg[0][base]), 32'hA0);
    chk("t3_d0", 32'(lg[0][base+1]), 32'h01);
    chk("t3_h1", 32'(lg[0][base+2]), 32'hA3);
    chk("t3_d1", 32'(lg[0][base+3]), 32'h31);
    chk("t3_h2", 32'(lg[0][base+4]), 32'hA0);
    chk("t3_d2", 32'(lg[0][base+5]), 32'h02);
    chk("t3_h3", 32'(lg[0][base+6]), 32'hA3);
    chk("t3_d3", 32'(lg[0][base+7]), 32'h32);
    wait_idle(0, "t3_idle");

    // Pointer wraps from 3 to 0 with 0 and 1 pending.
    base = nl[0];
    push(0, 3, 8'h33, 1'b1);
    wait_log(0, base + 1, "t4_hdr_sent");
    push(0, 0, 8'h0A, 1'b1);
    push(0, 1, 8'h1A, 1'b1);
    wait_log(0, base + 6, "t4_sent");
    chk("t4_h3", 32'(lg[0][base]), 32'hA3);
    chk("t4_d3", 32'(lg[0][base+1]), 32'h33);
    chk("t4_h0", 32'(lg[0][base+2]), 32'hA0);
    chk("t4_d0", 32'(lg[0][base+3]), 32'h0A);
    chk("t4_h1", 32'(lg[0][base+4]), 32'hA1);
    chk("t4_d1", 32'(lg[0][base+5]), 32'h1A);
    wait_idle(0, "t4_idle");

    // Requester 1 stalls mid-packet; timeout aborts and requester 2 is served.
    do_reset();
    base = nl[0];
    nab0 = nab[0];
    push(0, 1, 8'h11, 1'b0);
    wait_log(0, base + 1, "t5_hdr_sent");
    push(0, 2, 8'h22, 1'b1);
    wait_log(0, base + 2, "t5_byte_sent");
    k = 0;
    while (nab[0] == nab0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t5_abort_seen", 32'(nab[0] - nab0), 1);
    // Ready is first seen by the arbiter one edge after the model raises it.
    chk("t5_abort_delay", 32'(ab_cyc[0] - (rise_cyc[0] + 1)), 16);
    wait_log(0, base + 4, "t5_next_sent");
    wait_idle(0, "t5_idle");
    chk("t5_h1", 32'(lg[0][base]), 32'hA1);
    chk("t5_d1", 32'(lg[0][base+1]), 32'h11);
    chk("t5_h2", 32'(lg[0][base+2]), 32'hA2);
    chk("t5_d2", 32'(lg[0][base+3]), 32'h22);
    chk("t5_count", 32'(nl[0]), 32'(base + 4));
    chk("t5_abort_once", 32'(nab[0] - nab0), 1);

    // No header: requester 0 owns the line for its whole packet while 1 waits.
    do_reset();
    base = nl[1];
    t6_base = base;
    t6_on = 1'b1;
    push(1, 0, 8'hB0, 1'b0);
    push(1, 0, 8'hB1, 1'b0);
    push(1, 0, 8'hB2, 1'b1);
    push(1, 1, 8'hC1, 1'b1);
    wait_log(1, base + 4, "t6_sent");
    t6_on = 1'b0;
    chk("t6_d0", 32'(lg[1][base]), 32'hB0);
    chk("t6_d1", 32'(lg[1][base+1]), 32'hB1);
    chk("t6_d2", 32'(lg[1][base+2]), 32'hB2);
    chk("t6_d3", 32'(lg[1][base+3]), 32'hC1);
    chk("t6_no_early_rdy", 32'(t6_bad), 0);
    wait_idle(1, "t6_idle");
    chk("t6_grant1", 32'(bus_b.grant), 1);
    chk("t6_no_abort", 32'(nab[1]), 0);

    chk("uart_gap_a", 32'(viol[0]), 0);
    chk("uart_gap_b", 32'(viol[1]), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
